// File: rtl/gs_pkg.sv
// Shared types and constants for the Goldschmidt divider control slice.
// Holds the FSM state encoding, multiplicand select codes and the control word decode.
package gs_pkg;

  localparam int unsigned GS_WIDTH = 16;
  localparam int unsigned ITER_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_N = 2'd1,
    MUL_D = 2'd2,
    DONE  = 2'd3
  } gs_state_t;

  localparam logic [1:0] SEL_D    = 2'd0;
  localparam logic [1:0] SEL_N    = 2'd1;
  localparam logic [1:0] SEL_NEWD = 2'd2;
  localparam logic [1:0] SEL_NEWN = 2'd3;

  typedef struct packed {
    logic       k_select;
    logic [1:0] nd_select;
    logic       n_enable;
    logic       d_enable;
    logic       busy;
    logic       done;
  } gs_ctrl_t;

  typedef struct packed {
    logic [GS_WIDTH-1:0] n;
    logic [GS_WIDTH-1:0] d;
    logic [GS_WIDTH-1:0] ia;
  } gs_operands_t;

  // Moore control word for a given state/iteration; K comes from IA only on the first pair.
  function automatic gs_ctrl_t decode_ctrl(input gs_state_t st, input logic [ITER_W-1:0] it);
    gs_ctrl_t c;
    logic     first;
    c     = '0;
    first = (it == '0);
    case (st)
      MUL_N: begin
        c.n_enable  = 1'b1;
        c.busy      = 1'b1;
        c.k_select  = !first;
        c.nd_select = first ? SEL_N : SEL_NEWN;
      end
      MUL_D: begin
        c.d_enable  = 1'b1;
        c.busy      = 1'b1;
        c.k_select  = !first;
        c.nd_select = first ? SEL_D : SEL_NEWD;
      end
      DONE:    c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/flopenr.sv
// Enabled register with synchronous active-low clear.
module flopenr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/gs_divide_ctrl.sv
// Goldschmidt divider control: latches operands on start and sequences the shared
// multiplier through ITERS N-then-D iteration pairs, then pulses done for one cycle.
module gs_divide_ctrl
  import gs_pkg::*;
#(
  parameter int unsigned ITERS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [GS_WIDTH-1:0] N_in,
  input  logic [GS_WIDTH-1:0] D_in,
  input  logic [GS_WIDTH-1:0] IA_in,
  output logic [GS_WIDTH-1:0] N,
  output logic [GS_WIDTH-1:0] D,
  output logic [GS_WIDTH-1:0] IA,
  output logic                kSelect,
  output logic [1:0]          ndSelect,
  output logic                nEnable,
  output logic                dEnable,
  output logic                busy,
  output logic                done
);

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERS - 1);

  gs_state_t         state, next_state;
  logic [ITER_W-1:0] iter, next_iter;
  logic              load;
  gs_ctrl_t          ctrl_q, next_ctrl;
  gs_operands_t      ops_d, ops_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      iter   <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= next_state;
      iter   <= next_iter;
      ctrl_q <= next_ctrl;
    end
  end

  // Control word is decoded from the next state so outputs are registered yet Moore-aligned.
  always_comb begin
    next_state = state;
    next_iter  = iter;
    load       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          next_iter  = '0;
          next_state = MUL_N;
        end else begin
          next_state = IDLE;
        end
      end
      MUL_N: next_state = MUL_D;
      MUL_D: begin
        if (iter == LAST_ITER) begin
          next_state = DONE;
        end else begin
          next_iter  = iter + ITER_W'(1);
          next_state = MUL_N;
        end
      end
      default: next_state = IDLE;
    endcase
    next_ctrl = decode_ctrl(next_state, next_iter);
  end

  assign ops_d = '{n: N_in, d: D_in, ia: IA_in};

  flopenr #(.WIDTH(3 * GS_WIDTH)) u_operands (
    .clk   (clk),
    .reset (reset),
    .en    (load),
    .d     (ops_d),
    .q     (ops_q)
  );

  assign N        = ops_q.n;
  assign D        = ops_q.d;
  assign IA       = ops_q.ia;
  assign kSelect  = ctrl_q.k_select;
  assign ndSelect = ctrl_q.nd_select;
  assign nEnable  = ctrl_q.n_enable;
  assign dEnable  = ctrl_q.d_enable;
  assign busy     = ctrl_q.busy;
  assign done     = ctrl_q.done;

endmodule
